// File: rtl/signed_minmax6_pkg.sv
// Shared definitions for the signed min/max statistics stage.
package signed_minmax6_pkg;

    localparam int unsigned DATA_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/geq6.sv
// 6-bit two's-complement comparator: geq = (a >= b) as signed values.
module geq6
    import signed_minmax6_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              geq
);

    assign geq = $signed(a) >= $signed(b);

endmodule

// File: rtl/signed_minmax6.sv
// Burst statistics stage: running signed max/min of N_SAMPLES samples plus the
// index of the first occurrence of each, reported with a one-cycle done pulse.
module signed_minmax6
    import signed_minmax6_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned IDX_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic [IDX_W-1:0]  max_idx,
    output logic [IDX_W-1:0]  min_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  max_q;
    logic [DATA_W-1:0]  min_q;
    logic [IDX_W-1:0]   max_idx_q;
    logic [IDX_W-1:0]   min_idx_q;

    logic max_geq;
    logic min_geq;
    logic max_upd;
    logic min_upd;

    // Strict comparisons so ties keep the earliest index.
    geq6 u_max_cmp (
        .a   (max_q),
        .b   (in_data),
        .geq (max_geq)
    );

    geq6 u_min_cmp (
        .a   (in_data),
        .b   (min_q),
        .geq (min_geq)
    );

    assign max_upd = ~max_geq;
    assign min_upd = ~min_geq;

    // FSM, sample counter and result registers; in_ready is high in FIRST/ACCUM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FIRST;
                        cnt_q   <= '0;
                    end
                end
                FIRST: begin
                    if (in_valid) begin
                        max_q     <= in_data;
                        min_q     <= in_data;
                        max_idx_q <= '0;
                        min_idx_q <= '0;
                        cnt_q     <= IDX_W'(1);
                        state_q   <= (N_SAMPLES == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (max_upd) begin
                            max_q     <= in_data;
                            max_idx_q <= cnt_q;
                        end
                        if (min_upd) begin
                            min_q     <= in_data;
                            min_idx_q <= cnt_q;
                        end
                        cnt_q <= cnt_q + IDX_W'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status decoded from the state register only.
    assign in_ready = (state_q == FIRST) || (state_q == ACCUM);
    assign busy     = in_ready;
    assign done     = (state_q == DONE);

    assign max_out = max_q;
    assign min_out = min_q;
    assign max_idx = max_idx_q;
    assign min_idx = min_idx_q;

endmodule

// File: tb/tb_signed_minmax6.sv
// Bench for signed_minmax6: N=8 instance against a queue-based model every cycle,
// plus N=4 and N=1 instances with hand-computed expectations.
module tb_signed_minmax6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- N=8 instance ----------------
    logic       rst8 = 1'b0, start8 = 1'b0, valid8 = 1'b0;
    logic [5:0] data8 = '0;
    logic       ready8, busy8, done8;
    logic [5:0] max8, min8;
    logic [7:0] maxi8, mini8;

    signed_minmax6 #(.N_SAMPLES(8), .IDX_W(8)) dut8 (
        .clk(clk), .rst_n(rst8), .start(start8), .in_valid(valid8), .in_data(data8),
        .in_ready(ready8), .busy(busy8), .done(done8), .max_out(max8), .min_out(min8),
        .max_idx(maxi8), .min_idx(mini8)
    );

    // ---------------- N=4 instance ----------------
    logic       rst_s = 1'b0;
    logic       start4 = 1'b0, valid4 = 1'b0;
    logic [5:0] data4 = '0;
    logic       ready4, busy4, done4;
    logic [5:0] max4, min4;
    logic [7:0] maxi4, mini4;

    signed_minmax6 #(.N_SAMPLES(4), .IDX_W(8)) dut4 (
        .clk(clk), .rst_n(rst_s), .start(start4), .in_valid(valid4), .in_data(data4),
        .in_ready(ready4), .busy(busy4), .done(done4), .max_out(max4), .min_out(min4),
        .max_idx(maxi4), .min_idx(mini4)
    );

    // ---------------- N=1 instance ----------------
    logic       start1 = 1'b0, valid1 = 1'b0;
    logic [5:0] data1 = '0;
    logic       ready1, busy1, done1;
    logic [5:0] max1, min1;
    logic [7:0] maxi1, mini1;

    signed_minmax6 #(.N_SAMPLES(1), .IDX_W(8)) dut1 (
        .clk(clk), .rst_n(rst_s), .start(start1), .in_valid(valid1), .in_data(data1),
        .in_ready(ready1), .busy(busy1), .done(done1), .max_out(max1), .min_out(min1),
        .max_idx(maxi1), .min_idx(mini1)
    );

    // ---------------- Model for the N=8 instance ----------------
    logic [5:0] q[$];
    bit         m_active = 0;
    bit         m_done = 0;
    logic [5:0] m_max = '0, m_min = '0;
    logic [7:0] m_maxi = '0, m_mini = '0;
    bit         chk_en = 0;

    // Results are recomputed from the whole list of accepted samples.
    task automatic recompute();
        m_max = q[0];
        m_min = q[0];
        m_maxi = 8'd0;
        m_mini = 8'd0;
        for (int i = 1; i < q.size(); i++) begin
            if ($signed(q[i]) > $signed(m_max)) begin
                m_max = q[i];
                m_maxi = 8'(i);
            end
            if ($signed(q[i]) < $signed(m_min)) begin
                m_min = q[i];
                m_mini = 8'(i);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst8) begin
                m_active = 0;
                m_done = 0;
                m_max = '0;
                m_min = '0;
                m_maxi = '0;
                m_mini = '0;
                q.delete();
            end else if (m_done) begin
                m_done = 0;
            end else if (!m_active) begin
                if (start8) m_active = 1;
            end else if (valid8) begin
                q.push_back(data8);
                recompute();
                if (q.size() == 8) begin
                    m_active = 0;
                    m_done = 1;
                    q.delete();
                end
            end
        end
    end

    // Per-cycle comparison of every output of the N=8 instance.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready", 32'(ready8), 32'(m_active));
                chk("busy", 32'(busy8), 32'(m_active));
                chk("done", 32'(done8), 32'(m_done));
                chk("max_out", 32'(max8), 32'(m_max));
                chk("min_out", 32'(min8), 32'(m_min));
                chk("max_idx", 32'(maxi8), 32'(m_maxi));
                chk("min_idx", 32'(mini8), 32'(m_mini));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Stimulus tasks are entered and left just after a falling edge.
    task automatic start_burst8();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic send8(input logic [5:0] d, input int gaps);
        repeat (gaps) begin
            valid8 = 1'b0;
            data8 = 6'($urandom);
            @(negedge clk);
        end
        valid8 = 1'b1;
        data8 = d;
        @(negedge clk);
        valid8 = 1'b0;
    endtask

    logic [5:0] t1[8];
    logic [5:0] t2[8];
    logic [5:0] pat_d[7];
    logic       pat_v[7];

    initial begin
        t1 = '{6'd3, 6'h3B, 6'd31, 6'd0, 6'h20, 6'd31, 6'h20, 6'd7};
        t2 = '{6'd1, 6'h3F, 6'd2, 6'h3E, 6'd3, 6'h3D, 6'd0, 6'd0};
        pat_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        pat_d = '{6'd5, 6'h1F, 6'h20, 6'd9, 6'h3E, 6'h20, 6'd4};

        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset max_out", 32'(max8), 32'h0);
        chk("reset in_ready", 32'(ready8), 32'h0);
        chk("reset done", 32'(done8), 32'h0);
        rst8 = 1'b1;
        rst_s = 1'b1;
        @(negedge clk);

        // Mixed burst with duplicate extremes; first occurrences win.
        start_burst8();
        for (int i = 0; i < 8; i++) send8(t1[i], 0);
        chk("t1 done", 32'(done8), 32'h1);
        chk("t1 max", 32'(max8), 32'h1F);
        chk("t1 max_idx", 32'(maxi8), 32'd2);
        chk("t1 min", 32'(min8), 32'h20);
        chk("t1 min_idx", 32'(mini8), 32'd4);
        @(negedge clk);
        chk("t1 done pulse", 32'(done8), 32'h0);

        // start mid-ACCUM and during DONE must be ignored.
        start_burst8();
        for (int i = 0; i < 8; i++) begin
            start8 = (i == 3 || i == 4);
            send8(6'(i + 1), 0);
        end
        chk("restart done", 32'(done8), 32'h1);
        chk("restart max", 32'(max8), 32'd8);
        chk("restart max_idx", 32'(maxi8), 32'd7);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("start in DONE ignored", 32'(ready8), 32'h0);
        @(negedge clk);
        chk("idle stays idle", 32'(busy8), 32'h0);

        // Reset after 3 of 8 samples discards the partial burst.
        start_burst8();
        send8(6'd30, 0);
        send8(6'h22, 0);
        send8(6'd10, 0);
        rst8 = 1'b0;
        @(negedge clk);
        rst8 = 1'b1;
        chk("mid reset max", 32'(max8), 32'h0);
        chk("mid reset min", 32'(min8), 32'h0);
        chk("mid reset ready", 32'(ready8), 32'h0);
        start_burst8();
        for (int i = 0; i < 8; i++) send8(t2[i], 0);
        chk("t2 max", 32'(max8), 32'd3);
        chk("t2 max_idx", 32'(maxi8), 32'd4);
        chk("t2 min", 32'(min8), 32'h3D);
        chk("t2 min_idx", 32'(mini8), 32'd5);
        @(negedge clk);

        // Randomized bursts with stalls, extreme values and stray start pulses.
        for (int b = 0; b < 20; b++) begin
            start_burst8();
            for (int i = 0; i < 8; i++) begin
                logic [5:0] d;
                int sel;
                sel = int'($urandom_range(0, 5));
                d = (sel == 0) ? 6'h20 : (sel == 1) ? 6'h1F : 6'($urandom);
                start8 = ($urandom_range(0, 4) == 0);
                send8(d, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
            start8 = 1'b0;
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end

        // N=4: all-equal samples never move the indices.
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid4 = 1'b1;
            data4 = 6'h3F;
            @(negedge clk);
        end
        valid4 = 1'b0;
        chk("n4 eq done", 32'(done4), 32'h1);
        chk("n4 eq max", 32'(max4), 32'h3F);
        chk("n4 eq min", 32'(min4), 32'h3F);
        chk("n4 eq max_idx", 32'(maxi4), 32'd0);
        chk("n4 eq min_idx", 32'(mini4), 32'd0);
        @(negedge clk);

        // N=4: in_valid gaps carrying extreme junk data must not be accepted.
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            valid4 = pat_v[k];
            data4 = pat_d[k];
            @(negedge clk);
            if (k == 2) begin
                chk("n4 stall ready", 32'(ready4), 32'h1);
                chk("n4 stall done", 32'(done4), 32'h0);
            end
        end
        valid4 = 1'b0;
        chk("n4 stall done end", 32'(done4), 32'h1);
        chk("n4 stall max", 32'(max4), 32'd9);
        chk("n4 stall max_idx", 32'(maxi4), 32'd1);
        chk("n4 stall min", 32'(min4), 32'h3E);
        chk("n4 stall min_idx", 32'(mini4), 32'd2);
        @(negedge clk);
        chk("n4 done pulse", 32'(done4), 32'h0);

        // N=1: FIRST goes straight to DONE.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        valid1 = 1'b1;
        data1 = 6'h2C;
        @(negedge clk);
        valid1 = 1'b0;
        chk("n1 done", 32'(done1), 32'h1);
        chk("n1 max", 32'(max1), 32'h2C);
        chk("n1 min", 32'(min1), 32'h2C);
        chk("n1 max_idx", 32'(maxi1), 32'd0);
        chk("n1 min_idx", 32'(mini1), 32'd0);
        @(negedge clk);
        chk("n1 done pulse", 32'(done1), 32'h0);
        chk("n1 idle ready", 32'(ready1), 32'h0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
